irq_pending_unit: RTL and testbench

- Front end of the interrupt path: takes 8 raw asynchronous device lines and produces the `int_req[7:0]` vector that the priority encoder downstream resolves into Int / Int_Num.
- Synchronises each line and detects edges or levels per line.
- Holds pending bits and applies a software mask.
- Tracks a single in-service interrupt, so no new request reaches the encoder until the core signals end-of-interrupt.

---
 rtl/irq_pkg.sv | 11 +
 rtl/irq_sync_edge.sv | 34 +++
 rtl/irq_pending_unit.sv | 101 ++++++++++
 tb/tb_irq_pending_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending front end.
package irq_pkg;
    localparam int NUM_IRQ   = 8;
    localparam int IRQ_IDX_W = 3;
    localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

    typedef enum logic {
        IDLE       = 1'b0,
        IN_SERVICE = 1'b1
    } svc_state_e;
endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser plus one cycle of level history
// for rising-edge detection.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_src,
    output logic s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_d_q;
    logic                   s_d_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_src};
        s_d_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
endmodule

// File: rtl/irq_pending_unit.sv
// Interrupt front end: per-line sync/edge detect, pending and mask registers,
// and a single-depth in-service tracker gating requests to the encoder.
module irq_pending_unit
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_src,
    input  logic [NUM_IRQ-1:0]   irq_edge_mode,
    input  logic                 mask_wr,
    input  logic [NUM_IRQ-1:0]   mask_wdata,
    input  logic                 irq_ack,
    input  logic [IRQ_IDX_W-1:0] ack_num,
    input  logic                 eoi,
    output logic [NUM_IRQ-1:0]   int_req,
    output logic [NUM_IRQ-1:0]   mask_q,
    output logic [NUM_IRQ-1:0]   pending_q,
    output logic                 in_service,
    output logic [IRQ_IDX_W-1:0] isr_num,
    output logic                 spurious_ack
);
    svc_state_e            state_q, state_d;
    logic [NUM_IRQ-1:0]    mask_d;
    logic [NUM_IRQ-1:0]    pending_d;
    logic [IRQ_IDX_W-1:0]  isr_num_q, isr_num_d;
    logic                  spurious_ack_q, spurious_ack_d;
    logic                  ack_take;
    logic [NUM_IRQ-1:0]    sync_lvl;
    logic [NUM_IRQ-1:0]    rise;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .irq_src (irq_src[i]),
            .s       (sync_lvl[i]),
            .rise    (rise[i])
        );
    end

    assign int_req = pending_q & ~mask_q & {NUM_IRQ{state_q == IDLE}};

    always_comb begin
        state_d        = state_q;
        isr_num_d      = isr_num_q;
        spurious_ack_d = 1'b0;
        ack_take       = 1'b0;
        mask_d         = mask_wr ? mask_wdata : mask_q;

        case (state_q)
            IDLE: begin
                if (irq_ack) begin
                    if (int_req[ack_num]) begin
                        state_d   = IN_SERVICE;
                        isr_num_d = ack_num;
                        ack_take  = 1'b1;
                    end else begin
                        spurious_ack_d = 1'b1;
                    end
                end
            end
            IN_SERVICE: begin
                // Acks arriving while in service are dropped; eoi always wins.
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge in the same cycle as its own ack must not be lost.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge_mode[i]) begin
                pending_d[i] = rise[i] |
                    (pending_q[i] & ~(ack_take & (ack_num == IRQ_IDX_W'(i))));
            end else begin
                pending_d[i] = sync_lvl[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mask_q         <= MASK_RST;
            pending_q      <= '0;
            isr_num_q      <= '0;
            spurious_ack_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            pending_q      <= pending_d;
            isr_num_q      <= isr_num_d;
            spurious_ack_q <= spurious_ack_d;
        end
    end

    assign in_service   = (state_q == IN_SERVICE);
    assign isr_num      = isr_num_q;
    assign spurious_ack = spurious_ack_q;
endmodule

// File: tb/tb_irq_pending_unit.sv
// Directed bench for irq_pending_unit; expectations are queued with a target
// edge number and a monitor compares them after that edge.
module tb_irq_pending_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_src;
    logic [7:0] irq_edge_mode;
    logic       mask_wr;
    logic [7:0] mask_wdata;
    logic       irq_ack;
    logic [2:0] ack_num;
    logic       eoi;
    logic [7:0] int_req;
    logic [7:0] mask_q;
    logic [7:0] pending_q;
    logic       in_service;
    logic [2:0] isr_num;
    logic       spurious_ack;

    localparam int S_INT  = 0;
    localparam int S_PEND = 1;
    localparam int S_MASK = 2;
    localparam int S_SVC  = 3;
    localparam int S_ISR  = 4;
    localparam int S_SPUR = 5;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt    = 0;
    int   applied     = 0;
    int   miscompares = 0;

    irq_pending_unit dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src       (irq_src),
        .irq_edge_mode (irq_edge_mode),
        .mask_wr       (mask_wr),
        .mask_wdata    (mask_wdata),
        .irq_ack       (irq_ack),
        .ack_num       (ack_num),
        .eoi           (eoi),
        .int_req       (int_req),
        .mask_q        (mask_q),
        .pending_q     (pending_q),
        .in_service    (in_service),
        .isr_num       (isr_num),
        .spurious_ack  (spurious_ack)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "bench timed out");
    end

    function automatic logic [7:0] act_of(input int sel);
        case (sel)
            S_INT:   return int_req;
            S_PEND:  return pending_q;
            S_MASK:  return mask_q;
            S_SVC:   return {7'b0, in_service};
            S_ISR:   return {5'b0, isr_num};
            S_SPUR:  return {7'b0, spurious_ack};
            default: return 8'h00;
        endcase
    endfunction

    function automatic string name_of(input int sel);
        case (sel)
            S_INT:   return "int_req";
            S_PEND:  return "pending_q";
            S_MASK:  return "mask_q";
            S_SVC:   return "in_service";
            S_ISR:   return "isr_num";
            S_SPUR:  return "spurious_ack";
            default: return "unknown";
        endcase
    endfunction

    // Driver tasks: inputs change on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Expect 'val' on 'sel' right after the k-th upcoming rising edge.
    task automatic expect_at(input int sel, input logic [7:0] val, input int k);
        exp_t e;
        e.cyc = edge_cnt + k;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_reset_state();
        expect_at(S_INT,  8'h00, 1);
        expect_at(S_PEND, 8'h00, 1);
        expect_at(S_MASK, 8'hFF, 1);
        expect_at(S_SVC,  8'h00, 1);
        expect_at(S_ISR,  8'h00, 1);
        expect_at(S_SPUR, 8'h00, 1);
    endtask

    // Scoreboard monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            int i;
            logic [7:0] act;
            @(posedge clk);
            #1;
            edge_cnt++;
            i = 0;
            while (i < exp_q.size()) begin
                if (exp_q[i].cyc == edge_cnt) begin
                    applied++;
                    act = act_of(exp_q[i].sel);
                    if (act !== exp_q[i].val) begin
                        miscompares++;
                        $display("FAIL %s @edge %0d: got %02h expected %02h",
                                 name_of(exp_q[i].sel), edge_cnt, act, exp_q[i].val);
                    end
                    exp_q.delete(i);
                end else if (exp_q[i].cyc < edge_cnt) begin
                    applied++;
                    miscompares++;
                    $display("FAIL %s stale: got none expected %02h at edge %0d",
                             name_of(exp_q[i].sel), exp_q[i].val, exp_q[i].cyc);
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        irq_src       = 8'h00;
        irq_edge_mode = 8'hFF;
        mask_wr       = 1'b0;
        mask_wdata    = 8'h00;
        irq_ack       = 1'b0;
        ack_num       = 3'd0;
        eoi           = 1'b0;
        step_n(2);
        expect_reset_state();
        step();

        // Unmask all, edge pulse on line 5, ack, eoi.
        rst = 1'b0; mask_wr = 1'b1; mask_wdata = 8'h00;
        expect_at(S_MASK, 8'h00, 1);
        step();
        mask_wr = 1'b0; irq_src[5] = 1'b1;
        expect_at(S_INT, 8'h00, 2);
        expect_at(S_INT, 8'h20, 3);
        step();
        irq_src[5] = 1'b0;
        step_n(2);
        irq_ack = 1'b1; ack_num = 3'd5;
        expect_at(S_SVC,  8'h01, 1);
        expect_at(S_ISR,  8'h05, 1);
        expect_at(S_INT,  8'h00, 1);
        expect_at(S_PEND, 8'h00, 1);
        step();
        irq_ack = 1'b0; eoi = 1'b1;
        expect_at(S_SVC, 8'h00, 1);
        step();
        eoi = 1'b0;

        // Masked line still pends; unmasking exposes it.
        mask_wr = 1'b1; mask_wdata = 8'h04;
        step();
        mask_wr = 1'b0; irq_src[2] = 1'b1;
        expect_at(S_PEND, 8'h04, 3);
        expect_at(S_INT,  8'h00, 3);
        step();
        irq_src[2] = 1'b0;
        step_n(2);
        mask_wr = 1'b1; mask_wdata = 8'h00;
        expect_at(S_INT,  8'h04, 1);
        expect_at(S_PEND, 8'h04, 1);
        step();
        mask_wr = 1'b0; irq_ack = 1'b1; ack_num = 3'd2;
        expect_at(S_ISR, 8'h02, 1);
        step();
        irq_ack = 1'b0; eoi = 1'b1;
        step();
        eoi = 1'b0;

        // Level mode on line 1: ack does not clear, device must drop the line.
        irq_edge_mode = 8'hFD; irq_src[1] = 1'b1;
        expect_at(S_PEND, 8'h02, 3);
        expect_at(S_INT,  8'h02, 3);
        step_n(3);
        irq_ack = 1'b1; ack_num = 3'd1;
        expect_at(S_SVC,  8'h01, 1);
        expect_at(S_PEND, 8'h02, 1);
        expect_at(S_INT,  8'h00, 1);
        step();
        irq_ack = 1'b0;
        step();
        eoi = 1'b1;
        expect_at(S_SVC, 8'h00, 1);
        expect_at(S_INT, 8'h02, 1);
        step();
        eoi = 1'b0; irq_src[1] = 1'b0;
        expect_at(S_PEND, 8'h02, 2);
        expect_at(S_PEND, 8'h00, 3);
        step_n(3);
        irq_edge_mode = 8'hFF;

        // Spurious ack in IDLE.
        irq_ack = 1'b1; ack_num = 3'd3;
        expect_at(S_SPUR, 8'h01, 1);
        expect_at(S_SVC,  8'h00, 1);
        step();
        irq_ack = 1'b0;
        expect_at(S_SPUR, 8'h00, 1);
        step();

        // Service line 0, new edges on 0 and 7 arrive, then ack+eoi together.
        irq_src[0] = 1'b1;
        step_n(3);
        irq_ack = 1'b1; ack_num = 3'd0;
        expect_at(S_SVC,  8'h01, 1);
        expect_at(S_ISR,  8'h00, 1);
        expect_at(S_PEND, 8'h00, 1);
        step();
        irq_ack = 1'b0; irq_src[0] = 1'b0; irq_src[7] = 1'b1;
        step_n(2);
        irq_src[0] = 1'b1;
        expect_at(S_PEND, 8'h81, 3);
        expect_at(S_INT,  8'h00, 3);
        expect_at(S_SVC,  8'h01, 3);
        step_n(3);
        irq_ack = 1'b1; ack_num = 3'd7; eoi = 1'b1;
        expect_at(S_SVC,  8'h00, 1);
        expect_at(S_INT,  8'h81, 1);
        expect_at(S_PEND, 8'h81, 1);
        expect_at(S_SPUR, 8'h00, 1);
        step();
        eoi = 1'b0; ack_num = 3'd0; irq_src = 8'h00;
        expect_at(S_PEND, 8'h80, 1);
        step();
        irq_ack = 1'b0; eoi = 1'b1;
        step();
        eoi = 1'b0; irq_ack = 1'b1; ack_num = 3'd7;
        expect_at(S_PEND, 8'h00, 1);
        expect_at(S_ISR,  8'h07, 1);
        step();
        irq_ack = 1'b0; eoi = 1'b1;
        expect_at(S_SVC, 8'h00, 1);
        step();
        eoi = 1'b0;

        // Edge on line 4 in the same cycle as its accepted ack: set wins.
        irq_src[4] = 1'b1;
        expect_at(S_PEND, 8'h10, 3);
        step();
        irq_src[4] = 1'b0;
        step_n(2);
        irq_src[4] = 1'b1;
        step_n(2);
        irq_ack = 1'b1; ack_num = 3'd4;
        expect_at(S_SVC,  8'h01, 1);
        expect_at(S_ISR,  8'h04, 1);
        expect_at(S_PEND, 8'h10, 1);
        expect_at(S_INT,  8'h00, 1);
        step();

        // Reset while in service.
        irq_ack = 1'b0; irq_src[4] = 1'b0; rst = 1'b1;
        expect_reset_state();
        step();
        rst = 1'b0;
        step();

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        while (exp_q.size() != 0) begin
            applied++;
            miscompares++;
            $display("FAIL %s unchecked: got none expected %02h",
                     name_of(exp_q[0].sel), exp_q[0].val);
            void'(exp_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
